eaf_request_ctrl: RTL and testbench

EAF_REQUEST_CTRL -- requirements
Module: eaf_request_ctrl

---
 rtl/eaf_pkg.sv | 24 ++
 rtl/eaf_req_fifo.sv | 57 +++++
 rtl/eaf_request_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_eaf_request_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eaf_pkg.sv
// ----------------------------------------------------------------------------
// eaf_pkg
//   Shared types and constants for the EAF request controller.
//   - eaf_state_e    : controller FSM states (IDLE / ISSUE / WAIT)
//   - eaf_req_kind_e : kind of filter request in flight (insert / test)
//   - PRIO_LRU/MRU   : insertion-position encoding returned to the cache
// ----------------------------------------------------------------------------
package eaf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } eaf_state_e;

   typedef enum logic {
      REQ_INSERT = 1'b0,
      REQ_TEST   = 1'b1
   } eaf_req_kind_e;

   localparam logic PRIO_LRU = 1'b0;
   localparam logic PRIO_MRU = 1'b1;

endpackage

// File: rtl/eaf_req_fifo.sv
// ----------------------------------------------------------------------------
// eaf_req_fifo
//   Eviction-address queue. Synchronous push/pop, head visible without a pop
//   (first-word fall-through). Pointers carry one extra wrap bit so that full
//   and empty are told apart without a separate counter.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset (queue empties)
//   push, push_data   : write one entry (ignored while full)
//   pop               : drop the head entry (ignored while empty)
//   head              : current head entry
//   full, empty       : occupancy flags
// ----------------------------------------------------------------------------
module eaf_req_fifo #(
   parameter int width = 32,
   parameter int depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int aw = $clog2(depth);

   logic [width-1:0] mem [depth];
   logic [aw:0]      wr_ptr;
   logic [aw:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (aw+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (aw+1)'(1);
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[aw-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[aw-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);

endmodule

// File: rtl/eaf_request_ctrl.sv
// ----------------------------------------------------------------------------
// eaf_request_ctrl
//   Sequences cache evictions (filter inserts) and cache misses (filter tests)
//   onto a single-outstanding EAF filter port and returns the insertion
//   position for each miss to the cache.
//
//   Handshakes: a stream transfer happens in a cycle where valid and ready
//   are both high; ready does not depend on valid. One eviction and one miss
//   may transfer in the same cycle.
//
//   Ports:
//     clk, rst                          : clock, async active-low reset
//     evict_valid_i/evict_addr_i/evict_ready_o : eviction stream (queued)
//     miss_valid_i/miss_addr_i/miss_ready_o    : miss stream (one pending)
//     fill_valid_o + fill_addr/prio/exists/timeout_o : one-cycle result per
//                                         test; fields hold between pulses
//     eaf_mem_addr_o, eaf_insert_o, eaf_test_o : request to the filter
//     eaf_resp_i, eaf_priority_i, eaf_exists_i : filter response
//     state_o                           : current FSM state (debug)
//
//   Build option: define EAF_REQ_TIMEOUT_EN to abort a request after
//   timeout_cycles WAIT cycles without a response.
// ----------------------------------------------------------------------------
module eaf_request_ctrl
   import eaf_pkg::*;
#(
   parameter int addr_length    = 32,
   parameter int fifo_depth     = 4,
   parameter int timeout_cycles = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   evict_valid_i,
   input  logic [addr_length-1:0] evict_addr_i,
   output logic                   evict_ready_o,
   input  logic                   miss_valid_i,
   input  logic [addr_length-1:0] miss_addr_i,
   output logic                   miss_ready_o,
   output logic                   fill_valid_o,
   output logic [addr_length-1:0] fill_addr_o,
   output logic                   fill_prio_o,
   output logic                   fill_exists_o,
   output logic                   fill_timeout_o,
   output logic [addr_length-1:0] eaf_mem_addr_o,
   output logic                   eaf_insert_o,
   output logic                   eaf_test_o,
   input  logic                   eaf_resp_i,
   input  logic                   eaf_priority_i,
   input  logic                   eaf_exists_i,
   output logic [1:0]             state_o
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ISSUE = ISSUE;
   localparam logic [1:0] ST_WAIT  = WAIT;

   logic [1:0]             state;
   eaf_req_kind_e          req_kind;
   logic [addr_length-1:0] req_addr;
   logic                   miss_pending;
   logic [addr_length-1:0] miss_addr;

   logic                   fifo_full;
   logic                   fifo_empty;
   logic [addr_length-1:0] fifo_head;
   logic                   fifo_pop;
   logic                   evict_push;
   logic                   miss_accept;
   logic                   resp_done;
   logic                   timed_out;
   logic                   done;

   assign evict_ready_o = ~fifo_full;
   assign miss_ready_o  = ~miss_pending;
   assign evict_push    = evict_valid_i & evict_ready_o;
   assign miss_accept   = miss_valid_i & miss_ready_o;

   // Responses outside WAIT are dropped simply by not being looked at.
   assign resp_done = (state == ST_WAIT) & eaf_resp_i;
   assign done      = resp_done | timed_out;
   // The insert address is read from the head, so the entry leaves only now.
   assign fifo_pop  = done & (req_kind == REQ_INSERT);

   assign eaf_mem_addr_o = req_addr;
   assign eaf_test_o     = (state == ST_ISSUE) & (req_kind == REQ_TEST);
   assign eaf_insert_o   = (state == ST_ISSUE) & (req_kind == REQ_INSERT);
   assign state_o        = state;

   eaf_req_fifo #(
      .width (addr_length),
      .depth (fifo_depth)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (evict_push),
      .push_data (evict_addr_i),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         req_kind      <= REQ_INSERT;
         req_addr      <= '0;
         miss_pending  <= 1'b0;
         miss_addr     <= '0;
         fill_valid_o  <= 1'b0;
         fill_addr_o   <= '0;
         fill_prio_o   <= 1'b0;
         fill_exists_o <= 1'b0;
      end else begin
         fill_valid_o <= 1'b0;
         if (miss_accept) begin
            miss_pending <= 1'b1;
            miss_addr    <= miss_addr_i;
         end
         case (state)
            ST_IDLE: begin
               // A full queue blocks the cache's evictions, so drain it first;
               // otherwise a waiting miss beats ordinary queued inserts.
               if (fifo_full) begin
                  req_kind <= REQ_INSERT;
                  req_addr <= fifo_head;
                  state    <= ST_ISSUE;
               end else if (miss_pending) begin
                  req_kind <= REQ_TEST;
                  req_addr <= miss_addr;
                  state    <= ST_ISSUE;
               end else if (!fifo_empty) begin
                  req_kind <= REQ_INSERT;
                  req_addr <= fifo_head;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               if (done) begin
                  state <= ST_IDLE;
                  if (req_kind == REQ_TEST) begin
                     fill_valid_o  <= 1'b1;
                     fill_addr_o   <= miss_addr;
                     fill_prio_o   <= resp_done ? eaf_priority_i : PRIO_LRU;
                     fill_exists_o <= resp_done & eaf_exists_i;
                     miss_pending  <= 1'b0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef EAF_REQ_TIMEOUT_EN
   localparam int cnt_w = $clog2(timeout_cycles + 1);
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles - 1);

   logic [cnt_w-1:0] to_cnt;

   // to_cnt holds the number of WAIT cycles already spent without a response.
   assign timed_out = (state == ST_WAIT) & ~eaf_resp_i & (to_cnt == cnt_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt         <= '0;
         fill_timeout_o <= 1'b0;
      end else begin
         if (state != ST_WAIT) to_cnt <= '0;
         else if (!eaf_resp_i) to_cnt <= to_cnt + cnt_w'(1);
         if (done && (req_kind == REQ_TEST)) fill_timeout_o <= timed_out;
      end
   end
`else
   assign timed_out      = 1'b0;
   assign fill_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_eaf_request_ctrl.sv
// ----------------------------------------------------------------------------
// tb_eaf_request_ctrl
//   Directed scenarios followed by random traffic. The reference model keeps
//   the accepted evictions in order (exp_q), the single pending miss and the
//   one job the controller is working on, with the job's age in cycles since
//   it was picked: the filter request shows at age 1, a response counts from
//   age 2 on, and a test's result shows on the cycle after it completes.
// ----------------------------------------------------------------------------
module tb_eaf_request_ctrl;

   localparam int AW    = 32;
   localparam int DEPTH = 4;
`ifdef EAF_REQ_TIMEOUT_EN
   localparam int TO     = 8;
   localparam bit TO_EN  = 1'b1;
`else
   localparam int TO     = 64;
   localparam bit TO_EN  = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          evict_valid_i = 1'b0;
   logic [AW-1:0] evict_addr_i  = '0;
   logic          evict_ready_o;
   logic          miss_valid_i  = 1'b0;
   logic [AW-1:0] miss_addr_i   = '0;
   logic          miss_ready_o;
   logic          fill_valid_o;
   logic [AW-1:0] fill_addr_o;
   logic          fill_prio_o;
   logic          fill_exists_o;
   logic          fill_timeout_o;
   logic [AW-1:0] eaf_mem_addr_o;
   logic          eaf_insert_o;
   logic          eaf_test_o;
   logic          eaf_resp_i     = 1'b0;
   logic          eaf_priority_i = 1'b0;
   logic          eaf_exists_i   = 1'b0;
   logic [1:0]    state_o;

   eaf_request_ctrl #(
      .addr_length    (AW),
      .fifo_depth     (DEPTH),
      .timeout_cycles (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .evict_valid_i  (evict_valid_i),
      .evict_addr_i   (evict_addr_i),
      .evict_ready_o  (evict_ready_o),
      .miss_valid_i   (miss_valid_i),
      .miss_addr_i    (miss_addr_i),
      .miss_ready_o   (miss_ready_o),
      .fill_valid_o   (fill_valid_o),
      .fill_addr_o    (fill_addr_o),
      .fill_prio_o    (fill_prio_o),
      .fill_exists_o  (fill_exists_o),
      .fill_timeout_o (fill_timeout_o),
      .eaf_mem_addr_o (eaf_mem_addr_o),
      .eaf_insert_o   (eaf_insert_o),
      .eaf_test_o     (eaf_test_o),
      .eaf_resp_i     (eaf_resp_i),
      .eaf_priority_i (eaf_priority_i),
      .eaf_exists_i   (eaf_exists_i),
      .state_o        (state_o)
   );

   // ---------------- scoreboard / reference model ----------------
   int checks = 0;
   int errors = 0;

   logic [AW-1:0] exp_q[$];
   logic          m_pend;
   logic [AW-1:0] m_addr;
   logic          job_on;
   logic          job_test;
   logic [AW-1:0] job_addr;
   int            job_age;
   logic          f_v;
   logic [AW-1:0] f_addr;
   logic          f_prio;
   logic          f_ex;
   logic          f_to;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_pend   = 1'b0;
      m_addr   = '0;
      job_on   = 1'b0;
      job_test = 1'b0;
      job_addr = '0;
      job_age  = 0;
      f_v      = 1'b0;
      f_addr   = '0;
      f_prio   = 1'b0;
      f_ex     = 1'b0;
      f_to     = 1'b0;
   endtask

   task automatic check_outputs();
      check("evict_ready", evict_ready_o, exp_q.size() < DEPTH);
      check("miss_ready", miss_ready_o, !m_pend);
      check("eaf_test", eaf_test_o, job_on && job_age == 1 && job_test);
      check("eaf_insert", eaf_insert_o, job_on && job_age == 1 && !job_test);
      if (job_on) check("eaf_mem_addr", eaf_mem_addr_o, job_addr);
      check("fill_valid", fill_valid_o, f_v);
      check("fill_addr", fill_addr_o, f_addr);
      check("fill_prio", fill_prio_o, f_prio);
      check("fill_exists", fill_exists_o, f_ex);
      check("fill_timeout", fill_timeout_o, f_to);
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic cycle(input logic ev_v, input logic [AW-1:0] ev_a,
                        input logic mi_v, input logic [AW-1:0] mi_a,
                        input logic resp, input logic prio, input logic ex);
      logic ev_acc, mi_acc, got_resp, got_to, start;
      evict_valid_i  = ev_v;
      evict_addr_i   = ev_a;
      miss_valid_i   = mi_v;
      miss_addr_i    = mi_a;
      eaf_resp_i     = resp;
      eaf_priority_i = prio;
      eaf_exists_i   = ex;
      ev_acc   = ev_v && (exp_q.size() < DEPTH);
      mi_acc   = mi_v && !m_pend;
      got_resp = job_on && job_age >= 2 && resp;
      got_to   = TO_EN && job_on && !resp && job_age == TO + 1;
      start    = !job_on && (exp_q.size() > 0 || m_pend);
      @(posedge clk);
      f_v = 1'b0;
      if (got_resp || got_to) begin
         if (job_test) begin
            f_v    = 1'b1;
            f_addr = m_addr;
            f_prio = got_resp ? prio : 1'b0;
            f_ex   = got_resp ? ex : 1'b0;
            f_to   = got_to;
            m_pend = 1'b0;
         end else begin
            void'(exp_q.pop_front());
         end
         job_on = 1'b0;
      end else if (job_on) begin
         job_age++;
      end
      if (start) begin
         job_on  = 1'b1;
         job_age = 1;
         if (exp_q.size() == DEPTH) begin
            job_test = 1'b0;
            job_addr = exp_q[0];
         end else if (m_pend) begin
            job_test = 1'b1;
            job_addr = m_addr;
         end else begin
            job_test = 1'b0;
            job_addr = exp_q[0];
         end
      end
      if (ev_acc) exp_q.push_back(ev_a);
      if (mi_acc) begin
         m_pend = 1'b1;
         m_addr = mi_a;
      end
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n, input logic resp);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, resp, 1'b1, 1'b1);
   endtask

   task automatic evict(input logic [AW-1:0] a);
      cycle(1'b1, a, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst           = 1'b0;
      evict_valid_i = 1'b0;
      miss_valid_i  = 1'b0;
      eaf_resp_i    = 1'b0;
      #1;
      model_reset();
      check("rst_eaf_mem_addr", eaf_mem_addr_o, '0);
      check_outputs();
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check("rst_hold_fill_valid", fill_valid_o, 1'b0);
         check_outputs();
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_outputs();
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      model_reset();
      #1;
      check("rst_eaf_mem_addr", eaf_mem_addr_o, '0);
      check_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_outputs();

      // Single miss, filter answers one cycle after the test (MRU, exists).
      cycle(1'b0, '0, 1'b1, 32'hCAFE_0040, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      idle(2, 1'b0);

      // Four back-to-back evictions against a stalled filter, one refused,
      // then the four inserts drain in order with spurious responses present.
      evict(32'h0000_1001);
      evict(32'h0000_1002);
      evict(32'h0000_1003);
      evict(32'h0000_1004);
      evict(32'h0000_1005);
      idle(3, 1'b0);
      idle(20, 1'b1);

      // Two queued inserts plus a pending miss: the test goes before both.
      evict(32'h0000_2000);
      idle(2, 1'b0);
      evict(32'h0000_2001);
      cycle(1'b1, 32'h0000_2002, 1'b1, 32'h0000_2FFF, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      idle(20, 1'b1);

      // Full queue plus a miss arriving while idle: the insert goes first.
      cycle(1'b0, '0, 1'b1, 32'h0000_3FFF, 1'b0, 1'b0, 1'b0);
      evict(32'h0000_3000);
      evict(32'h0000_3001);
      evict(32'h0000_3002);
      evict(32'h0000_3003);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 32'h0000_3EEE, 1'b0, 1'b0, 1'b0);
      idle(30, 1'b1);

      // Eviction and miss in the same cycle while idle.
      cycle(1'b1, 32'h0000_4000, 1'b1, 32'h0000_4FFF, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      idle(15, 1'b1);

`ifdef EAF_REQ_TIMEOUT_EN
      // Unanswered test and unanswered insert both abort after TO WAIT cycles.
      cycle(1'b0, '0, 1'b1, 32'h0000_5FFF, 1'b0, 1'b0, 1'b0);
      idle(TO + 6, 1'b0);
      evict(32'h0000_5000);
      idle(TO + 6, 1'b0);
`endif

      // Reset while an insert is in WAIT with three entries and a miss queued.
      evict(32'h0000_6000);
      idle(2, 1'b0);
      evict(32'h0000_6001);
      cycle(1'b1, 32'h0000_6002, 1'b1, 32'h0000_6FFF, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      do_reset(2);
      idle(6, 1'b1);

      // Random traffic with random filter latency and spurious responses.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset(1);
         cycle($urandom_range(0, 99) < 40, $urandom,
               $urandom_range(0, 99) < 25, $urandom,
               $urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      idle(TO + 8, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
